// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches; data side has priority,
// with a starvation counter for fetch. Define MEM_TIMEOUT_EN to add the grant timeout and TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t        state;
  logic [SW-1:0] starve;
  logic          dreq;
  logic          active;
  logic          done;
  logic          fault;

  assign dreq   = dREN | dWEN;
  assign active = (state == DSERV) ? dreq : ((state == ISERV) ? iREN : 1'b0);
  assign done   = active && (ramstate == RAM_ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;
  logic          expired;

  assign expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign fault   = active && ((ramstate == RAM_ERROR) || ((ramstate != RAM_ACCESS) && expired));
`else
  assign fault   = active && (ramstate == RAM_ERROR);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
      merr   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_TIMEOUT_EN
          tcnt <= '0;
`endif
          if (iREN && (starve >= SW'(STARVE_MAX))) state <= ISERV;
          else if (dreq)                           state <= DSERV;
          else if (iREN)                           state <= ISERV;
        end
        default: begin
          // Every grant ends after completion, error, timeout or withdrawal: one IDLE cycle between grants.
          if (!active || done || fault) state <= IDLE;
          if (fault) merr <= 1'b1;
          if (done) begin
            if (state == ISERV)
              starve <= '0;
            else if (iREN && (starve != SW'(STARVE_MAX)))
              starve <= starve + 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          if (!done) tcnt <= tcnt + 1'b1;
`endif
        end
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      DSERV: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
        dwait = !done;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = !done;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a behavioural owner/queue model.
module tb_mem_arbiter;
  localparam int SM = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  // Model: who owns the RAM (0 none, 1 data, 2 instruction), how many data wins fetch has suffered.
  int owner = 0;
  int starved = 0;
  int age = 0;
  bit m_merr = 0;

  logic        s_iwait, s_dwait, s_ramREN, s_ramWEN, s_merr;
  logic [31:0] s_iload;

  mem_arbiter #(
    .STARVE_MAX(SM)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_iw, e_dw, e_r, e_w;
    logic [31:0] e_addr, e_store;
    e_iw = 1; e_dw = 1; e_r = 0; e_w = 0; e_addr = 0; e_store = 0;
    if (owner == 1) begin
      e_addr = daddr;
      if (dWEN) begin e_w = 1; e_store = dstore; end
      else if (dREN) e_r = 1;
      if ((dREN || dWEN) && ramstate == 2'd2) e_dw = 0;
    end else if (owner == 2) begin
      e_addr = iaddr;
      e_r = iREN;
      if (iREN && ramstate == 2'd2) e_iw = 0;
    end
    chk("iwait", {31'd0, iwait}, {31'd0, e_iw});
    chk("dwait", {31'd0, dwait}, {31'd0, e_dw});
    chk("ramREN", {31'd0, ramREN}, {31'd0, e_r});
    chk("ramWEN", {31'd0, ramWEN}, {31'd0, e_w});
    chk("merr", {31'd0, merr}, {31'd0, m_merr});
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    if (e_r || e_w) chk("ramaddr", ramaddr, e_addr);
    if (e_w) chk("ramstore", ramstore, e_store);
    s_iwait = iwait; s_dwait = dwait; s_ramREN = ramREN; s_ramWEN = ramWEN;
    s_merr = merr; s_iload = iload;
  endtask

  task automatic model_step();
    bit act;
    if (owner == 0) begin
      age = 0;
      if (iREN && starved >= SM) owner = 2;
      else if (dREN || dWEN)     owner = 1;
      else if (iREN)             owner = 2;
    end else begin
      act = (owner == 1) ? (dREN || dWEN) : iREN;
      if (!act) owner = 0;
      else if (ramstate == 2'd2) begin
        if (owner == 2) starved = 0;
        else if (iREN && starved < SM) starved = starved + 1;
        owner = 0;
      end else if (ramstate == 2'd3) begin
        m_merr = 1;
        owner = 0;
      end else begin
`ifdef MEM_TIMEOUT_EN
        if (age == TO - 1) begin m_merr = 1; owner = 0; end
        else age++;
`endif
      end
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
  endtask

  task automatic check_reset_values();
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_merr", {31'd0, merr}, 32'd0);
    owner = 0; starved = 0; age = 0; m_merr = 0;
  endtask

  initial begin
    int dcomp, icomp, dafter, iw0;
    nRST = 0; idle_inputs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #2;
    check_reset_values();
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;

    // Instruction fetch answered immediately.
    iREN = 1; iaddr = 32'h40; ramstate = 2'd2; ramload = 32'h8C010004;
    cycle();
    chk("fetch_req_iwait", {31'd0, s_iwait}, 32'd1);
    cycle();
    chk("fetch_iwait", {31'd0, s_iwait}, 32'd0);
    chk("fetch_iload", s_iload, 32'h8C010004);
    iREN = 0; cycle();

    // Data write, RAM busy for three cycles.
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wr_busy_dwait", {31'd0, s_dwait}, 32'd1);
      chk("wr_busy_ramWEN", {31'd0, s_ramWEN}, 32'd1);
    end
    ramstate = 2'd2; cycle();
    chk("wr_done_dwait", {31'd0, s_dwait}, 32'd0);
    chk("wr_done_iwait", {31'd0, s_iwait}, 32'd1);
    dWEN = 0; cycle();

    // ERROR during a data read: merr sticks, request is re-granted after IDLE.
    dREN = 1; daddr = 32'h200; ramstate = 2'd0; cycle();
    ramstate = 2'd3; cycle();
    chk("err_dwait", {31'd0, s_dwait}, 32'd1);
    ramstate = 2'd2; cycle();
    chk("err_merr", {31'd0, s_merr}, 32'd1);
    cycle();
    chk("retry_dwait", {31'd0, s_dwait}, 32'd0);
    dREN = 0; cycle();
    chk("err_merr_sticky", {31'd0, s_merr}, 32'd1);

    // Fetch withdrawn mid-grant, then data request served through IDLE.
    iREN = 1; iaddr = 32'h80; ramstate = 2'd1; cycle();
    cycle();
    iREN = 0; cycle();
    chk("withdraw_ramREN", {31'd0, s_ramREN}, 32'd0);
    dREN = 1; daddr = 32'h300; cycle();
    cycle();
    chk("after_withdraw_ramREN", {31'd0, s_ramREN}, 32'd1);

    // Asynchronous reset in the middle of a busy data grant.
    #1; nRST = 0; #1;
    check_reset_values();
    idle_inputs();
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;

    // Both sides requesting continuously, every access one cycle.
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h400; ramstate = 2'd2;
    dcomp = 0; icomp = 0; dafter = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (!s_dwait) begin
        if (icomp == 0) dcomp++;
        else dafter++;
      end
      if (!s_iwait) icomp++;
    end
    chk("starve_dcomp", dcomp, 32'd4);
    chk("starve_icomp", icomp, 32'd1);
    chk("starve_resume", dafter, 32'd1);
    idle_inputs(); cycle();

`ifdef MEM_TIMEOUT_EN
    #1; nRST = 0; #1;
    check_reset_values();
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;
    iREN = 1; iaddr = 32'h48; ramstate = 2'd1; iw0 = 0;
    cycle();
    for (int k = 0; k < TO; k++) begin
      cycle();
      if (!s_iwait) iw0++;
    end
    cycle();
    chk("timeout_merr", {31'd0, s_merr}, 32'd1);
    chk("timeout_iwait", iw0, 32'd0);
    idle_inputs(); cycle();
`else
    iw0 = 0;
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int r;
      iREN = 1'($urandom_range(0, 1));
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 2) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 40) ? 2'd2 : (r < 70) ? 2'd1 : (r < 97) ? 2'd0 : 2'd3;
      cycle();
    end
    if (iw0 != 0) errors = errors;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction cache and the data cache on one side, and the unified RAM on the other.
- Consumes the cache-side iREN/iaddr and dREN/dWEN/daddr requests that the caches raise on a miss or writeback.
- Grants the RAM port to one requester at a time and returns wait/load handshakes.
- Data side has priority; a bounded starvation counter guarantees forward progress for instruction fetch.

Parameters:
- STARVE_MAX, 4, consecutive data grants completed while iREN is pending before the instruction side is forced ahead.
- TIMEOUT_CYCLES, 64, cycles a grant may wait for ACCESS before it is abandonned; used only with MEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iwait  out  1  0 = iload valid this cycle
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  data write value
- dwait  out  1  0 = data transaction completes this cycle
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- merr  out  1  sticky memory error flag

Behaviour:
- One clock CLK; nRST is asynchronous, active-low.
- Reset values: state=IDLE, starve counter=0, merr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1. iload and dload are continuous copies of ramload.
- States: IDLE, DSERV, ISERV. The state register is the only grant source. All RAM-side outputs and the waits are combinational from state plus the granted requester's inputs.
- Transitions from IDLE, evaluated each cycle:
  - If iREN=1 and starve counter >= STARVE_MAX: go to ISERV.
  - Else if dREN|dWEN: go to DSERV.
  - Else if iREN: go to ISERV.
  - Else stay in IDLE.
- IDLE: ramREN=ramWEN=0; iwait=dwait=1.
- DSERV:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore (write wins when both are set).
  - Else: ramREN=1.
  - iwait=1.
- ISERV: ramaddr=iaddr, ramREN=iREN, ramWEN=0, dwait=1.
- Completion: in a grant state with ramstate==ACCESS, the granted wait is 0 that same cycle and the next state is IDLE.
  - Minimum latency: request in cycle N, grant in N+1, completion in N+1 if RAM answers ACCESS immediately.
  - Back-to-back transactions always pass through one IDLE cycle.
- FREE or BUSY in a grant state: hold the state; the wait stays 1.
- ERROR in a grant state: set merr=1 (cleared only by reset), keep the wait at 1, go to IDLE. The requester retries.
- Request withdrawn mid-grant (granted side's enables all 0): RAM enables drop to 0 combinationally that cycle; next state is IDLE; no counter update.
- Starve counter:
  - On DSERV completion with iREN=1: increment, saturating at STARVE_MAX.
  - On ISERV completion: clear to 0.
  - Width is clog2(STARVE_MAX+1).
- Simultaneous iREN and dREN in IDLE with counter below STARVE_MAX: DSERV wins.
- The requester's address and data are not latched; the cache must hold its inputs stable until its wait goes to 0.
- nRST asserted mid-transaction: immediate return to the reset values above; the in-flight RAM access is dropped.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter clears on entry to DSERV or ISERV and increments each cycle in a grant state without ACCESS.
  - When it reaches TIMEOUT_CYCLES-1 without ACCESS: set merr, keep the wait at 1, go to IDLE next cycle.
- MEM_TIMEOUT_EN undefined: no counter is built; a grant waits for ACCESS or ERROR indefinitely.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS in its first granted cycle with ramload=0x8C010004 -> ISERV one cycle after the request; iwait=0 and iload=0x8C010004 in that cycle; IDLE next.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, RAM BUSY 3 cycles then ACCESS -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF for 4 granted cycles; dwait=0 only in the 4th; iwait=1 throughout.
- iREN and dREN held high together, every access 1 cycle, STARVE_MAX=4 -> four DSERV completions, then one ISERV; the counter returns to 0 and data service resumes.
- ramstate=ERROR during DSERV -> merr=1 next cycle and stays 1; dwait stays 1; the arbiter re-grants the same request after one IDLE cycle.
- iREN dropped to 0 in the second ISERV cycle while BUSY -> ramREN=0 that cycle; IDLE next; dREN raised then is granted the following cycle.
- With MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, RAM held BUSY -> merr=1 after 8 granted cycles; IDLE; iwait never 0.
